pulse_stretch_tx: RTL and testbench
===================================

// Module: pulse_stretch_tx
// PURPOSE
//  Source-domain launcher feeding sync_pulse in a destination clock domain.
//  - Converts single-cycle event pulses into registered level pulses long enough to survive
//    the destination synchronizer.
//  - Enforces a guaranteed low gap after each level pulse, so every accepted event produces
//    exactly one rising edge downstream.
//  - Events arriving while busy are queued in a saturating pending counter.
// PARAMETERS
//  HIGH_CYCLES  3  sig_o high time per event, in clk_i cycles; >=1, else elaboration error
//  LOW_CYCLES   3  minimum sig_o low time after each high phase; >=1, else elaboration error
//  PEND_DEPTH   4  maximum queued events; >=1, else elaboration error
//  PEND_W       $clog2(PEND_DEPTH+1)  derived width of pend_o; do not override
// PORTS
//  clk_i    in   1       source-domain clock; single clock, all state on rising edge
//  rst_i    in   1       reset, synchronous, active-high
//  pulse_i  in   1       event strobe; every high cycle is one event
//  sig_o    out  1       stretched level toward destination sync_pulse.sig_i; registered
//  busy_o   out  1       high when state != IDLE
//  pend_o   out  PEND_W  queued events not yet launched; registered
//  ovf_o    out  1       sticky drop flag; present only with PULSE_STRETCH_TX_OVF_EN
// BEHAVIOUR
//  - Reset (rst_i=1 at a clk_i edge) takes priority over everything. Afterwards:
//    state=IDLE, sig_o=0, busy_o=0, pend_o=0, ovf_o=0, phase counter=0.
//  - Reset mid-operation: in-flight and queued events are discarded; no further edges.
//  - States: IDLE, HIGH, LOW. A down-counter sized for max(HIGH_CYCLES,LOW_CYCLES) times each phase.
//  - IDLE: pulse_i=1 -> HIGH. sig_o=1 from the next cycle (latency 1). pend_o unchanged.
//  - HIGH: sig_o=1 for exactly HIGH_CYCLES cycles, then -> LOW.
//  - LOW: sig_o=0 for exactly LOW_CYCLES cycles. In the last LOW cycle:
//    - if pend_o>0: -> HIGH, pend_o-1;
//    - else if pulse_i=1: -> HIGH, that event launches directly, pend_o unchanged;
//    - else -> IDLE.
//  - pulse_i=1 in HIGH or LOW, when it does not launch directly:
//    - pend_o<PEND_DEPTH: pend_o+1;
//    - pend_o==PEND_DEPTH: event dropped, pend_o held.
//  - Simultaneous launch from queue and new pulse_i in the last LOW cycle: net pend_o unchanged.
//  - Consecutive rising edges on sig_o are exactly HIGH_CYCLES+LOW_CYCLES apart when backlogged.
//  - Invariant: pend_o>0 implies busy_o=1. pend_o never wraps.
//  - Integration: HIGH_CYCLES and LOW_CYCLES must each exceed
//    (SYNC_DEPTH+1) x the destination clock period, in source cycles (integration check).
//  - Number of accepted events equals the number of sig_o rising edges, absent reset.
// CONFIGURATION
//  - PULSE_STRETCH_TX_OVF_EN defined:
//    - ovf_o exists. It is registered and sets the cycle after an event is dropped.
//    - It stays set until rst_i; there is no other clear.
//  - PULSE_STRETCH_TX_OVF_EN undefined:
//    - ovf_o port and its register are absent.
//    - Drops are silent; all other behaviour is identical.
// TESTING (defaults 3/3/4; cycle n = pulse_i sampled at end of cycle n)
//  1. Single pulse_i at cycle 0:
//     sig_o=1 cycles 1-3, 0 cycles 4-6; busy_o=0 from cycle 7; pend_o=0 throughout.
//  2. pulse_i at cycles 0,1,2:
//     pend_o=1 at cycle 2, 2 at cycle 3, 1 at cycle 7, 0 at cycle 13;
//     sig_o rises at cycles 1,7,13; IDLE at cycle 19.
//  3. pulse_i held cycles 0-5 (6 events): pend_o saturates at 4 from cycle 5;
//     ovf_o=1 from cycle 6 (macro on);
//     exactly 5 rising edges (cycles 1,7,13,19,25); ovf_o stays 1 until rst_i.
//  4. pulse_i at cycle 0 and cycle 6 (last LOW cycle):
//     sig_o high again at cycle 7 with no IDLE gap; pend_o stays 0.
//  5. pulse_i at cycles 0,1; rst_i=1 at cycle 2:
//     cycle 3 shows sig_o=0, pend_o=0, busy_o=0, ovf_o=0; no edge after cycle 1.
//  6. HIGH_CYCLES=1, LOW_CYCLES=1, PEND_DEPTH=1, pulse_i held 10 cycles:
//     sig_o toggles 1,0,1,0 from cycle 1; drops counted; edges every 2 cycles.

Source files
------------

// File: rtl/pulse_stretch_tx.sv
// Turns single-cycle event strobes into fixed-length level pulses separated by a guaranteed low gap.
// Events that arrive while busy wait in a saturating counter. Define PULSE_STRETCH_TX_OVF_EN to get the sticky ovf_o drop flag.
module pulse_stretch_tx #(
  parameter  int HIGH_CYCLES = 3,
  parameter  int LOW_CYCLES  = 3,
  parameter  int PEND_DEPTH  = 4,
  localparam int PEND_W      = $clog2(PEND_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pulse_i,
  output logic              sig_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pend_o
`ifdef PULSE_STRETCH_TX_OVF_EN
  ,
  output logic              ovf_o
`endif
);

  localparam int MAXC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  if (HIGH_CYCLES < 1) begin : g_bad_high
    $error("pulse_stretch_tx: HIGH_CYCLES must be >= 1");
  end
  if (LOW_CYCLES < 1) begin : g_bad_low
    $error("pulse_stretch_tx: LOW_CYCLES must be >= 1");
  end
  if (PEND_DEPTH < 1) begin : g_bad_depth
    $error("pulse_stretch_tx: PEND_DEPTH must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_sig;
  logic [PEND_W-1:0] r_pend;

  logic w_lastLow;
  logic w_qLaunch;
  logic w_direct;
  logic w_enqReq;
  logic w_drop;

  // A launch from the queue takes priority in the last LOW cycle, so a simultaneous new event queues instead of launching.
  always_comb begin
    w_lastLow = (r_state == S_LOW) && (r_cnt == '0);
    w_qLaunch = w_lastLow && (r_pend != '0);
    w_direct  = pulse_i && ((r_state == S_IDLE) || (w_lastLow && (r_pend == '0)));
    w_enqReq  = pulse_i && !w_direct;
    w_drop    = w_enqReq && !w_qLaunch && (r_pend == PEND_W'(PEND_DEPTH));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sig   <= 1'b0;
      r_pend  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pulse_i) begin
            r_state <= S_HIGH;
            r_sig   <= 1'b1;
            r_cnt   <= CW'(HIGH_CYCLES - 1);
          end
        end
        S_HIGH: begin
          if (r_cnt == '0) begin
            r_state <= S_LOW;
            r_sig   <= 1'b0;
            r_cnt   <= CW'(LOW_CYCLES - 1);
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_LOW: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (w_qLaunch || w_direct) begin
            r_state <= S_HIGH;
            r_sig   <= 1'b1;
            r_cnt   <= CW'(HIGH_CYCLES - 1);
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_sig   <= 1'b0;
          r_cnt   <= '0;
        end
      endcase

      if (w_qLaunch && !w_enqReq) begin
        r_pend <= r_pend - PEND_W'(1);
      end else if (!w_qLaunch && w_enqReq && !w_drop) begin
        r_pend <= r_pend + PEND_W'(1);
      end
    end
  end

  assign sig_o  = r_sig;
  assign busy_o = (r_state != S_IDLE);
  assign pend_o = r_pend;

`ifdef PULSE_STRETCH_TX_OVF_EN
  logic r_ovf;

  // Sticky: only reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf_o = r_ovf;
`else
  // Without the flag a dropped event leaves no trace.
  logic w_unusedDrop;
  assign w_unusedDrop = w_drop;
`endif

endmodule

// File: tb/tb_pulse_stretch_tx.sv
// Directed bench for pulse_stretch_tx: default 3/3/4 instance driven from a vector table,
// plus a 1/1/1 instance exercised with a held strobe.
module tb_pulse_stretch_tx;

  logic       clk;
  logic       rst;
  logic       pulse;
  logic       sig;
  logic       busy;
  logic [2:0] pend;
  logic       rst6;
  logic       pulse6;
  logic       sig6;
  logic       busy6;
  logic [0:0] pend6;
`ifdef PULSE_STRETCH_TX_OVF_EN
  logic       ovf;
  logic       ovf6;
`endif

  int nChecks = 0;
  int nPass   = 0;
  int edges6  = 0;
  logic prevSig6 = 1'b0;

  typedef struct {
    logic       rst;
    logic       pulse;
    logic       sig;
    logic       busy;
    logic [2:0] pend;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  pulse_stretch_tx dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .pulse_i (pulse),
    .sig_o   (sig),
    .busy_o  (busy),
    .pend_o  (pend)
`ifdef PULSE_STRETCH_TX_OVF_EN
    ,
    .ovf_o   (ovf)
`endif
  );

  pulse_stretch_tx #(
    .HIGH_CYCLES (1),
    .LOW_CYCLES  (1),
    .PEND_DEPTH  (1)
  ) dut6 (
    .clk_i   (clk),
    .rst_i   (rst6),
    .pulse_i (pulse6),
    .sig_o   (sig6),
    .busy_o  (busy6),
    .pend_o  (pend6)
`ifdef PULSE_STRETCH_TX_OVF_EN
    ,
    .ovf_o   (ovf6)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sig6 && !prevSig6) edges6++;
    prevSig6 = sig6;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic addRun(input int n, input bit r, input bit p, input bit s,
                        input bit b, input int pd, input bit o);
    vec_t v;
    v.rst = r; v.pulse = p; v.sig = s; v.busy = b; v.pend = 3'(pd); v.ovf = o;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic applyStimulus(input bit r, input bit p);
    rst   = r;
    pulse = p;
  endtask

  initial begin
    rst = 1'b1; pulse = 1'b0; rst6 = 1'b1; pulse6 = 1'b0;

    // Test 1: single event
    addRun(1,0,1,0,0,0,0); addRun(3,0,0,1,1,0,0); addRun(3,0,0,0,1,0,0); addRun(1,0,0,0,0,0,0);
    // Test 2: three back-to-back events
    addRun(1,0,1,0,0,0,0); addRun(1,0,1,1,1,0,0); addRun(1,0,1,1,1,1,0); addRun(1,0,0,1,1,2,0);
    addRun(3,0,0,0,1,2,0); addRun(3,0,0,1,1,1,0); addRun(3,0,0,0,1,1,0); addRun(3,0,0,1,1,0,0);
    addRun(3,0,0,0,1,0,0); addRun(1,0,0,0,0,0,0);
    // Test 3: six events, queue saturates and one is dropped
    addRun(1,0,1,0,0,0,0); addRun(1,0,1,1,1,0,0); addRun(1,0,1,1,1,1,0); addRun(1,0,1,1,1,2,0);
    addRun(1,0,1,0,1,3,0); addRun(1,0,1,0,1,4,0); addRun(1,0,0,0,1,4,1);
    addRun(3,0,0,1,1,3,1); addRun(3,0,0,0,1,3,1); addRun(3,0,0,1,1,2,1); addRun(3,0,0,0,1,2,1);
    addRun(3,0,0,1,1,1,1); addRun(3,0,0,0,1,1,1); addRun(3,0,0,1,1,0,1); addRun(3,0,0,0,1,0,1);
    addRun(1,0,0,0,0,0,1); addRun(1,1,0,0,0,0,1);
    // Test 4: event in last LOW cycle launches directly
    addRun(1,0,1,0,0,0,0); addRun(3,0,0,1,1,0,0); addRun(2,0,0,0,1,0,0); addRun(1,0,1,0,1,0,0);
    addRun(3,0,0,1,1,0,0); addRun(3,0,0,0,1,0,0); addRun(1,0,0,0,0,0,0);
    // Test 5: reset mid-operation discards everything
    addRun(1,0,1,0,0,0,0); addRun(1,0,1,1,1,0,0); addRun(1,1,0,1,1,1,0); addRun(4,0,0,0,0,0,0);

    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      checkOutput($sformatf("sig[%0d]", i),  int'(sig),  int'(vecs[i].sig));
      checkOutput($sformatf("busy[%0d]", i), int'(busy), int'(vecs[i].busy));
      checkOutput($sformatf("pend[%0d]", i), int'(pend), int'(vecs[i].pend));
`ifdef PULSE_STRETCH_TX_OVF_EN
      checkOutput($sformatf("ovf[%0d]", i),  int'(ovf),  int'(vecs[i].ovf));
`endif
      applyStimulus(vecs[i].rst, vecs[i].pulse);
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 1'b0);

    // Test 6: 1/1/1 instance with strobe held for ten cycles
    rst6 = 1'b0;
    edges6 = 0;
    for (int c = 0; c < 14; c++) begin
      checkOutput($sformatf("t6 sig[%0d]", c),  int'(sig6),  int'(c >= 1 && c <= 11 && (c % 2) == 1));
      checkOutput($sformatf("t6 pend[%0d]", c), int'(pend6), int'(c >= 2 && c <= 10));
      checkOutput($sformatf("t6 busy[%0d]", c), int'(busy6), int'(c >= 1 && c <= 12));
      pulse6 = (c <= 9);
      @(posedge clk); #1;
    end
    pulse6 = 1'b0;
    checkOutput("t6 edges", edges6, 6);
`ifdef PULSE_STRETCH_TX_OVF_EN
    checkOutput("t6 ovf", int'(ovf6), 1);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
